// File: rtl/rod2_motion_ctrl.sv
// Rod position FSM and sprite pixel addressing for the rod2 renderer.
// Define ROD_LATCH_EN to make the trigger a press-to-toggle latch instead of hold-to-lower.
module rod2_motion_ctrl #(
  parameter int ROD_X0          = 564,
  parameter int Y_TOP           = 210,
  parameter int Y_BOTTOM        = 290,
  parameter int SPRITE_W        = 64,
  parameter int SPRITE_H        = 16,
  parameter int STEP            = 2,
  parameter int FRAMES_PER_STEP = 1
) (
  input  logic       vga_clk,
  input  logic       reset,
  input  logic       vs,
  input  logic       trigger,
  input  logic [9:0] DrawX,
  input  logic [9:0] DrawY,
  output logic [9:0] rom_address,
  output logic       rod_hit,
  output logic [9:0] rod_y,
  output logic       at_top,
  output logic       at_bottom
);

  localparam int CNT_W = (FRAMES_PER_STEP > 1) ? $clog2(FRAMES_PER_STEP) : 1;

  typedef enum logic [1:0] {TOP, DOWN, BOTTOM, UP} state_e;

  state_e           state_q, state_d;
  logic [9:0]       rod_y_q, rod_y_d;
  logic [CNT_W-1:0] frame_cnt_q, frame_cnt_d;
  logic             at_top_q, at_top_d, at_bottom_q, at_bottom_d;
  logic             trig_meta_q, trig_s_q, vs_q;
  logic [9:0]       addr_q, addr_d;
  logic             hit_q, hit_d;
  logic             frame_tick, step, want_down;
  logic [10:0]      down_sum;
  logic             up_floor;
  logic [10:0]      x_off, y_off;
  logic             in_x, in_y;

  // Trigger comes from a mechanical lever, so it is synchronised before use.
  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      trig_meta_q <= 1'b0;
      trig_s_q    <= 1'b0;
      vs_q        <= 1'b0;
    end else begin
      trig_meta_q <= trigger;
      trig_s_q    <= trig_meta_q;
      vs_q        <= vs;
    end
  end

  assign frame_tick = vs_q & ~vs;
  assign step       = frame_tick && (frame_cnt_q == CNT_W'(FRAMES_PER_STEP - 1));

`ifdef ROD_LATCH_EN
  logic trig_prev_q, latch_q;

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      trig_prev_q <= 1'b0;
      latch_q     <= 1'b0;
    end else begin
      trig_prev_q <= trig_s_q;
      if (trig_s_q && !trig_prev_q) latch_q <= ~latch_q;
    end
  end

  assign want_down = latch_q;
`else
  assign want_down = trig_s_q;
`endif

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      state_q     <= TOP;
      rod_y_q     <= 10'(Y_TOP);
      frame_cnt_q <= '0;
      at_top_q    <= 1'b1;
      at_bottom_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rod_y_q     <= rod_y_d;
      frame_cnt_q <= frame_cnt_d;
      at_top_q    <= at_top_d;
      at_bottom_q <= at_bottom_d;
    end
  end

  // Widened sums let the clamp detect overshoot before it wraps.
  assign down_sum = {1'b0, rod_y_q} + 11'(STEP);
  assign up_floor = ({1'b0, rod_y_q} <= 11'(Y_TOP + STEP));

  always_comb begin
    state_d     = state_q;
    rod_y_d     = rod_y_q;
    frame_cnt_d = frame_cnt_q;
    if (frame_tick) begin
      if (state_q == DOWN || state_q == UP)
        frame_cnt_d = step ? '0 : frame_cnt_q + CNT_W'(1);
      unique case (state_q)
        TOP:    if (want_down) state_d = DOWN;
        DOWN: begin
          if (!want_down) state_d = UP;
          else if (step) begin
            if (down_sum >= 11'(Y_BOTTOM)) begin
              rod_y_d = 10'(Y_BOTTOM);
              state_d = BOTTOM;
            end else rod_y_d = down_sum[9:0];
          end
        end
        BOTTOM: if (!want_down) state_d = UP;
        UP: begin
          if (want_down) state_d = DOWN;
          else if (step) begin
            if (up_floor) begin
              rod_y_d = 10'(Y_TOP);
              state_d = TOP;
            end else rod_y_d = rod_y_q - 10'(STEP);
          end
        end
        default: state_d = TOP;
      endcase
    end
  end

  always_comb begin
    at_top_d    = (state_d == TOP);
    at_bottom_d = (state_d == BOTTOM);
  end

  // Offsets are taken in 11 bits so pixels left of / above the sprite fail the range test.
  assign x_off = {1'b0, DrawX} - 11'(ROD_X0);
  assign y_off = {1'b0, DrawY} - {1'b0, rod_y_q};
  assign in_x  = ({1'b0, DrawX} >= 11'(ROD_X0)) && (x_off < 11'(SPRITE_W));
  assign in_y  = (DrawY >= rod_y_q) && (y_off < 11'(SPRITE_H));

  always_comb begin
    hit_d  = in_x && in_y;
    addr_d = '0;
    if (in_x && in_y) addr_d = 10'(x_off + y_off * 11'(SPRITE_W));
  end

  always_ff @(posedge vga_clk or posedge reset) begin
    if (reset) begin
      addr_q <= '0;
      hit_q  <= 1'b0;
    end else begin
      addr_q <= addr_d;
      hit_q  <= hit_d;
    end
  end

  assign rom_address = addr_q;
  assign rod_hit     = hit_q;
  assign rod_y       = rod_y_q;
  assign at_top      = at_top_q;
  assign at_bottom   = at_bottom_q;

endmodule
